// File: rtl/wb_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_cfg_pkg
// Description : Shared definitions for the Wishbone bitstream loader and the
//               fabric configuration slave.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_cfg_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_WORD = 3'd1;
    localparam logic [2:0] ST_BUS       = 3'd2;
    localparam logic [2:0] ST_DONE      = 3'd3;
    localparam logic [2:0] ST_ERR       = 3'd4;

    localparam logic [3:0]  WB_SEL_ALL        = 4'hF;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_WAIT_WORD = ST_WAIT_WORD,
        S_BUS       = ST_BUS,
        S_DONE      = ST_DONE,
        S_ERR       = ST_ERR
    } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/wb_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : wb_timeout_counter
// Description : Per-transfer ack watchdog; loaded on bus entry, counts down
//               while enabled and flags the last permitted cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    // Counter holds TIMEOUT-1 at most; zero marks the final allowed bus cycle.
    localparam int              TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] c_LOAD = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_LOAD;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - TO_W'(1);
        end
    end

    assign o_expired = i_en && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/wb_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : wb_config_loader
// Description : Streams 32-bit bitstream words into a Wishbone configuration
//               slave as single-beat classic writes at consecutive addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_config_loader
    import wb_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          NUM_WORDS = 64,
    parameter int          TIMEOUT   = 255,
    parameter int          CNT_W     = $clog2(NUM_WORDS + 1)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             word_valid_i,
    input  logic [31:0]      word_data_i,
    output logic             word_ready_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [CNT_W-1:0] words_sent_o
);

    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(NUM_WORDS - 1);

    loader_state_e    r_state;
    loader_state_e    w_next;
    logic             w_start_ok;
    logic             w_accept;
    logic             w_ack_ok;
    logic             w_in_bus;
    logic             w_expired;
    logic [31:0]      w_adr_next;

    logic             r_cyc;
    logic [3:0]       r_sel;
    logic [31:0]      r_adr;
    logic [31:0]      r_dat;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [CNT_W-1:0] r_words_sent;

    assign w_in_bus   = (r_state == S_BUS);
    assign w_start_ok = start_i && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                    (r_state == S_ERR));
    // Abort wins over a same-cycle handshake or ack; neither is taken.
    assign w_accept   = (r_state == S_WAIT_WORD) && word_valid_i && !abort_i;
    assign w_ack_ok   = w_in_bus && wbm_ack_i && !abort_i;
    // The sent count doubles as the word index: both clear on start and step on ack.
    assign w_adr_next = BASE_ADDR + (32'(r_words_sent) << 2);

    wb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .i_clear   (w_start_ok),
        .i_load    (w_accept),
        .i_en      (w_in_bus),
        .o_expired (w_expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) w_next = S_WAIT_WORD;
            end
            S_WAIT_WORD: begin
                if (abort_i)           w_next = S_ERR;
                else if (word_valid_i) w_next = S_BUS;
            end
            S_BUS: begin
                if (abort_i) begin
                    w_next = S_ERR;
                end else if (wbm_ack_i) begin
                    w_next = (r_words_sent == c_LAST_IDX) ? S_DONE : S_WAIT_WORD;
                end else if (w_expired) begin
                    w_next = S_ERR;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Every output is a flop loaded from the next state, so no input reaches a port combinationally.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cyc        <= 1'b0;
            r_sel        <= '0;
            r_adr        <= '0;
            r_dat        <= '0;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_words_sent <= '0;
        end else begin
            if (w_start_ok) begin
                r_words_sent <= '0;
            end else if (w_ack_ok) begin
                r_words_sent <= r_words_sent + CNT_W'(1);
            end
            if (w_accept) begin
                r_dat <= word_data_i;
                r_adr <= w_adr_next;
            end
            r_cyc   <= (w_next == S_BUS);
            r_sel   <= (w_next == S_BUS) ? WB_SEL_ALL : 4'h0;
            r_ready <= (w_next == S_WAIT_WORD);
            r_busy  <= (w_next == S_WAIT_WORD) || (w_next == S_BUS);
            r_done  <= (w_next == S_DONE);
            r_error <= (w_next == S_ERR);
        end
    end

    assign word_ready_o = r_ready;
    assign wbm_cyc_o    = r_cyc;
    assign wbm_stb_o    = r_cyc;
    assign wbm_we_o     = r_cyc;
    assign wbm_sel_o    = r_sel;
    assign wbm_adr_o    = r_adr;
    assign wbm_dat_o    = r_dat;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign error_o      = r_error;
    assign words_sent_o = r_words_sent;

endmodule
`default_nettype wire

// File: tb/tb_wb_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_config_loader
// Description : Self-checking bench for wb_config_loader with a wait-state
//               slave, a gappable word source and an outcome reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_config_loader;
    import wb_cfg_pkg::*;

    localparam int          N    = 4;
    localparam int          TO   = 8;
    localparam int          CW   = $clog2(N + 1);
    localparam logic [31:0] BASE = 32'h3000_0000;

    typedef struct {
        int wait_st;
        bit gap;
        bit pulse;
        int exp_state;   // 1 = DONE, 2 = ERR
        int exp_ws;
        int exp_lat;     // cycles from start edge to done/error, -1 = unchecked
    } vec_t;

    logic          clk = 1'b0;
    logic          rst, start, abort_m, valid, ack, slv_abort, w_abort;
    logic [31:0]   data;
    logic          word_ready_o, wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]    wbm_sel_o;
    logic [31:0]   wbm_adr_o, wbm_dat_o;
    logic          busy_o, done_o, error_o;
    logic [CW-1:0] words_sent_o;

    int            n_vec = 0;
    int            n_err = 0;

    int            waits [N];
    int            slv_cnt = 0, slv_idx = 0, abort_idx = -1, prot_err = 0;
    logic [31:0]   hold_adr, hold_dat;
    logic [31:0]   wr_adr[$], wr_dat[$];

    logic [31:0]   src_words [N];
    int            src_pos = 0;
    bit            src_en = 0, src_gap = 0, src_phase = 0, src_take = 0;

    vec_t          tbl [5];

    assign w_abort = abort_m | slv_abort;

    always #5 clk = ~clk;

    wb_config_loader #(
        .BASE_ADDR (BASE),
        .NUM_WORDS (N),
        .TIMEOUT   (TO)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .start_i      (start),
        .abort_i      (w_abort),
        .word_valid_i (valid),
        .word_data_i  (data),
        .word_ready_o (word_ready_o),
        .wbm_cyc_o    (wbm_cyc_o),
        .wbm_stb_o    (wbm_stb_o),
        .wbm_we_o     (wbm_we_o),
        .wbm_sel_o    (wbm_sel_o),
        .wbm_adr_o    (wbm_adr_o),
        .wbm_dat_o    (wbm_dat_o),
        .wbm_ack_i    (ack),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .words_sent_o (words_sent_o)
    );

    // Slave: acks after waits[idx] wait states, records writes, checks bus rules.
    always @(negedge clk) begin
        ack = 1'b0;
        if (wbm_stb_o !== wbm_cyc_o || wbm_we_o !== wbm_cyc_o ||
            wbm_sel_o !== (wbm_cyc_o ? WB_SEL_ALL : 4'h0))
            prot_err++;
        if (word_ready_o && (wbm_cyc_o || done_o || error_o))
            prot_err++;
        if (wbm_stb_o) begin
            if (slv_cnt == 0) begin
                hold_adr = wbm_adr_o;
                hold_dat = wbm_dat_o;
            end else if (wbm_adr_o !== hold_adr || wbm_dat_o !== hold_dat) begin
                prot_err++;
            end
            if (slv_idx < N && slv_cnt == waits[slv_idx]) begin
                ack = 1'b1;
                if (slv_idx == abort_idx) begin
                    slv_abort = 1'b1;
                end else begin
                    wr_adr.push_back(wbm_adr_o);
                    wr_dat.push_back(wbm_dat_o);
                end
                slv_idx++;
            end
            slv_cnt++;
        end else begin
            slv_cnt   = 0;
            slv_abort = 1'b0;
        end
    end

    // Source: offers words in order, optionally on alternate cycles only.
    always @(negedge clk) begin
        if (src_take) src_pos++;
        src_phase = !src_phase;
        valid     = src_en && (src_pos < N) && (!src_gap || src_phase);
        data      = (src_pos < N) ? src_words[src_pos] : 32'h0;
        src_take  = valid && word_ready_o;
    end

    function automatic logic [127:0] outs();
        return {50'h0, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
                word_ready_o, busy_o, done_o, error_o, words_sent_o};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_load(input string tag, input bit pulse, input int exp_state,
                            input int exp_ws, input int exp_lat);
        int lat;
        int idx;
        slv_idx  = 0;
        src_pos  = 0;
        src_take = 0;
        prot_err = 0;
        wr_adr.delete();
        wr_dat.delete();
        src_en   = 1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        check({tag, " ws_clear"}, words_sent_o, 0);
        while (!(done_o || error_o) && lat < 600) begin
            start = pulse && (lat == 5);
            @(posedge clk); #1;
            lat++;
        end
        start  = 1'b0;
        src_en = 0;
        check({tag, " finished"}, lat < 600, 1);
        check({tag, " status"}, {done_o, error_o}, (exp_state == 1) ? 2'b10 : 2'b01);
        check({tag, " words_sent"}, words_sent_o, exp_ws);
        if (exp_lat >= 0) check({tag, " latency"}, lat, exp_lat);
        check({tag, " write_count"}, wr_adr.size(), exp_ws);
        for (int k = 0; k < exp_ws && k < wr_adr.size(); k++) begin
            check($sformatf("%s adr%0d", tag, k), wr_adr[k], BASE + 32'(4 * k));
            check($sformatf("%s dat%0d", tag, k), wr_dat[k], src_words[k]);
        end
        check({tag, " protocol"}, prot_err, 0);
        check({tag, " idle_bus"}, {busy_o, wbm_cyc_o, word_ready_o}, 3'b000);
        idx = (exp_state == 1) ? N - 1 : exp_ws;
        check({tag, " hold_adr"}, wbm_adr_o, BASE + 32'(4 * idx));
        check({tag, " hold_dat"}, wbm_dat_o, src_words[idx]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        int k_fail;
        int lat_m;
        bit gap_r;
        bit pulse_r;

        tbl[0] = '{0,      0, 0, 1, N, 9};
        tbl[1] = '{3,      0, 0, 1, N, 21};
        tbl[2] = '{TO - 1, 0, 0, 1, N, 37};
        tbl[3] = '{TO,     0, 0, 2, 0, 10};
        tbl[4] = '{1,      1, 1, 1, N, -1};

        rst = 1'b1; start = 1'b0; abort_m = 1'b0;
        for (int k = 0; k < N; k++) begin
            waits[k]     = 0;
            src_words[k] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), '0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_outputs", outs(), '0);

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < N; k++) begin
                waits[k]     = tbl[i].wait_st;
                src_words[k] = (i == 0) ? 32'hA0 + 32'(k) : $urandom;
            end
            src_gap = tbl[i].gap;
            run_load($sformatf("vec%0d", i), tbl[i].pulse, tbl[i].exp_state,
                     tbl[i].exp_ws, tbl[i].exp_lat);
        end

        // Abort coincides with the ack of the second word.
        for (int k = 0; k < N; k++) begin
            waits[k]     = (k == 1) ? 1 : 0;
            src_words[k] = $urandom;
        end
        src_gap   = 0;
        abort_idx = 1;
        run_load("abort_ack", 0, 2, 1, 6);
        abort_idx = -1;

        // Reset while the third word is on the bus, then a clean reload.
        for (int k = 0; k < N; k++) begin
            waits[k]     = (k == 2) ? 20 : 0;
            src_words[k] = $urandom;
        end
        slv_idx  = 0;
        src_pos  = 0;
        src_take = 0;
        src_en   = 1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt   = 0;
        while (!(wbm_stb_o && slv_idx == 2) && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("rst_reach_word3", cnt < 100, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_outputs", outs(), '0);
        rst    = 1'b0;
        src_en = 0;
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) waits[k] = 0;
        run_load("after_rst", 0, 1, N, 9);

        // Randomised loads checked against an outcome model built from the wait list.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < N; k++) begin
                waits[k]     = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TO, TO + 1))
                                                           : int'($urandom_range(0, TO - 1));
                src_words[k] = $urandom;
            end
            gap_r   = 1'($urandom_range(0, 1));
            pulse_r = 1'($urandom_range(0, 1));
            k_fail  = N;
            for (int k = N - 1; k >= 0; k--) if (waits[k] >= TO) k_fail = k;
            lat_m = 1;
            for (int k = 0; k < k_fail; k++) lat_m += waits[k] + 2;
            if (k_fail < N) lat_m += 1 + TO;
            src_gap = gap_r;
            run_load($sformatf("rnd%0d", r), pulse_r, (k_fail == N) ? 1 : 2, k_fail,
                     gap_r ? -1 : lat_m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
